// File: rtl/rsa_const_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rsa_const_calc                                             |
// | Description : Iterative Montgomery constant generator. Computes          |
// |               Const = 2^(2*WIDTH) mod P with a shift-and-conditional-    |
// |               subtract loop, one bit per clock, and holds the result     |
// |               until the next computation. Even or zero moduli complete   |
// |               immediately with err set.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rsa_const_calc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] const_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // Remainder register is one bit wider than the modulus.
   localparam int RW = WIDTH + 1;
   // Iteration counter must hold values up to 2*WIDTH-1 with headroom.
   localparam int CNT_W = $clog2(2 * WIDTH) + 1;
   // Counter value of the final iteration.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state_q,  state_d;
   logic [RW-1:0]      r_q,      r_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   p_reg_q,  p_reg_d;
   logic               inv_q,    inv_d;
   logic [WIDTH-1:0]   const_q,  const_d;
   logic               done_q,   done_d;
   logic               err_q,    err_d;

   // Shifted remainder. Because r < p_reg always holds, the top bit of this
   // vector is always zero; it exists only so the full r register feeds it.
   logic [WIDTH+1:0]   t;
   logic               t_ge_p;

   // State register: synchronous active-low reset, ena freezes everything.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         cnt_q   <= '0;
         p_reg_q <= '0;
         inv_q   <= 1'b0;
         const_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         p_reg_q <= p_reg_d;
         inv_q   <= inv_d;
         const_q <= const_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // One reduction step: double the remainder and subtract p_reg if it fits.
   always_comb begin
      t      = {r_q, 1'b0};
      t_ge_p = (t >= {2'b00, p_reg_q});
   end

   // Next-state and datapath control for the IDLE / CALC / FIN sequence.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      p_reg_d = p_reg_q;
      inv_d   = inv_q;
      const_d = const_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               p_reg_d = P;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (!P[0]) begin
                  // Zero or even modulus: no Montgomery constant exists.
                  inv_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  inv_d   = 1'b0;
                  // P==1 starts from 0 so the remainder stays below p_reg.
                  r_d     = (P == WIDTH'(1)) ? RW'(0) : RW'(1);
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            r_d   = t_ge_p ? RW'(t - {2'b00, p_reg_q}) : RW'(t);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIN;
            end
         end

         S_FIN: begin
            done_d = 1'b1;
            if (inv_q) begin
               const_d = '0;
               err_d   = 1'b1;
            end else begin
               const_d = r_q[WIDTH-1:0];
               err_d   = 1'b0;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output mapping; busy covers both the iteration and completion states.
   always_comb begin
      busy      = (state_q != S_IDLE);
      const_out = const_q;
      done      = done_q;
      err       = err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_rsa_const_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rsa_const_calc                                          |
// | Description : Self-checking bench for rsa_const_calc, reference results  |
// |               from plain modular arithmetic on 2^(2*W).                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rsa_const_calc;

   localparam int W       = 8;
   localparam int LAT_OK  = 2 * W + 1;
   localparam int MAX_CYC = 200;

   logic         clk;
   logic         rstb;
   logic         ena;
   logic         start;
   logic [W-1:0] P;
   logic [W-1:0] const_out;
   logic         busy;
   logic         done;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   rsa_const_calc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .ena       (ena),
      .start     (start),
      .P         (P),
      .const_out (const_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the constant is simply 2^(2W) mod P for odd P.
   function automatic logic [W-1:0] ref_const(input int unsigned p);
      longint unsigned m;
      if (p == 0 || (p % 2) == 0) return '0;
      m = (64'd1 << (2 * W)) % longint'(p);
      return W'(m);
   endfunction

   function automatic logic ref_err(input int unsigned p);
      return (p == 0 || (p % 2) == 0);
   endfunction

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present start with modulus p for exactly one edge.
   task automatic launch(input logic [W-1:0] p);
      start = 1'b1;
      P     = p;
      step();
      start = 1'b0;
   endtask

   // Count edges after the accepting edge until done is seen.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!done && lat < MAX_CYC);
   endtask

   task automatic test_reset();
      rstb = 1'b0; ena = 1'b1; start = 1'b0; P = '0;
      step();
      step();
      n_tests++; if (const_out !== '0) begin n_fail++; $display("FAIL reset_const got=%0d exp=0", const_out); end
      n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      rstb = 1'b1;
      step();
   endtask

   task automatic test_directed();
      logic [W-1:0] pl [5] = '{8'd187, 8'd233, 8'd255, 8'd3, 8'd1};
      logic [W-1:0] el [5] = '{8'd86, 8'd63, 8'd1, 8'd1, 8'd0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         launch(pl[i]);
         n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy p=%0d got=%b exp=1", pl[i], busy); end
         wait_done(lat);
         n_tests++; if (lat != LAT_OK)      begin n_fail++; $display("FAIL dir_latency p=%0d got=%0d exp=%0d", pl[i], lat, LAT_OK); end
         n_tests++; if (const_out !== el[i]) begin n_fail++; $display("FAIL dir_const p=%0d got=%0d exp=%0d", pl[i], const_out, el[i]); end
         n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL dir_err p=%0d got=%b exp=0", pl[i], err); end
         n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL dir_busy_end p=%0d got=%b exp=0", pl[i], busy); end
         step();
         n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL dir_done_pulse p=%0d got=%b exp=0", pl[i], done); end
         n_tests++; if (const_out !== el[i]) begin n_fail++; $display("FAIL dir_hold p=%0d got=%0d exp=%0d", pl[i], const_out, el[i]); end
      end
   endtask

   task automatic test_invalid();
      logic [W-1:0] pl [3];
      int lat;
      pl[0] = 8'd0;
      pl[1] = 8'd100;
      pl[2] = W'($urandom_range(1, 127) * 2);
      for (int i = 0; i < 3; i++) begin
         launch(pl[i]);
         n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_cleared p=%0d got=%b exp=0", pl[i], err); end
         wait_done(lat);
         n_tests++; if (lat != 1)            begin n_fail++; $display("FAIL inv_latency p=%0d got=%0d exp=1", pl[i], lat); end
         n_tests++; if (err !== 1'b1)        begin n_fail++; $display("FAIL inv_err p=%0d got=%b exp=1", pl[i], err); end
         n_tests++; if (const_out !== '0)    begin n_fail++; $display("FAIL inv_const p=%0d got=%0d exp=0", pl[i], const_out); end
         n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL inv_busy p=%0d got=%b exp=0", pl[i], busy); end
         step();
      end
   endtask

   task automatic test_random();
      int unsigned p;
      int lat;
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 5) == 0) p = $urandom_range(0, 255);
         else                           p = $urandom_range(1, 127) * 2 + 1;
         launch(W'(p));
         wait_done(lat);
         n_tests++; if (lat != (ref_err(p) ? 1 : LAT_OK)) begin n_fail++; $display("FAIL rnd_latency p=%0d got=%0d exp=%0d", p, lat, ref_err(p) ? 1 : LAT_OK); end
         n_tests++; if (const_out !== ref_const(p))      begin n_fail++; $display("FAIL rnd_const p=%0d got=%0d exp=%0d", p, const_out, ref_const(p)); end
         n_tests++; if (err !== ref_err(p))              begin n_fail++; $display("FAIL rnd_err p=%0d got=%b exp=%b", p, err, ref_err(p)); end
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   task automatic test_interference();
      int lat;
      launch(8'd187);
      lat = 0;
      do begin
         if (lat == 4) begin start = 1'b1; P = 8'd233; end
         if (lat == 5) begin start = 1'b0; P = 8'hAA; end
         step();
         lat++;
      end while (!done && lat < MAX_CYC);
      n_tests++; if (lat != LAT_OK)      begin n_fail++; $display("FAIL intf_latency got=%0d exp=%0d", lat, LAT_OK); end
      n_tests++; if (const_out !== 8'd86) begin n_fail++; $display("FAIL intf_const got=%0d exp=86", const_out); end
      step();
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL intf_no_restart got=%b exp=0", busy); end
      launch(8'd233);
      wait_done(lat);
      n_tests++; if (const_out !== 8'd63) begin n_fail++; $display("FAIL intf_fresh got=%0d exp=63", const_out); end
      step();
   endtask

   task automatic test_ena_gating();
      int lat;
      launch(8'd233);
      lat = 0;
      do begin
         if (lat == 5) ena = 1'b0;
         if (lat == 8) ena = 1'b1;
         step();
         lat++;
      end while (!done && lat < MAX_CYC);
      ena = 1'b1;
      n_tests++; if (lat != LAT_OK + 3)   begin n_fail++; $display("FAIL ena_latency got=%0d exp=%0d", lat, LAT_OK + 3); end
      n_tests++; if (const_out !== 8'd63) begin n_fail++; $display("FAIL ena_const got=%0d exp=63", const_out); end
      step();
      // A start presented while disabled is lost.
      ena = 1'b0; start = 1'b1; P = 8'd187;
      step();
      start = 1'b0; ena = 1'b1;
      step();
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL ena_start_lost got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen_done;
      launch(8'd187);
      for (int i = 0; i < 7; i++) step();
      rstb = 1'b0;
      step();
      n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_tests++; if (const_out !== '0) begin n_fail++; $display("FAIL rstmid_const got=%0d exp=0", const_out); end
      rstb = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) seen_done++;
      end
      n_tests++; if (seen_done != 0)   begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=0", seen_done); end
      launch(8'd187);
      wait_done(lat);
      n_tests++; if (const_out !== 8'd86) begin n_fail++; $display("FAIL rstmid_restart got=%0d exp=86", const_out); end
   endtask

   task automatic test_back_to_back();
      int lat;
      // Entered right after a done: start in the cycle done is high.
      launch(8'd255);
      n_tests++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", busy); end
      n_tests++; if (done !== 1'b0)       begin n_fail++; $display("FAIL b2b_done_low got=%b exp=0", done); end
      wait_done(lat);
      n_tests++; if (lat != LAT_OK)       begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT_OK); end
      n_tests++; if (const_out !== 8'd1)  begin n_fail++; $display("FAIL b2b_const got=%0d exp=1", const_out); end
      launch(8'd0);
      wait_done(lat);
      n_tests++; if (err !== 1'b1)        begin n_fail++; $display("FAIL b2b_err got=%b exp=1", err); end
      launch(8'd3);
      wait_done(lat);
      n_tests++; if (err !== 1'b0)        begin n_fail++; $display("FAIL b2b_err_clr got=%b exp=0", err); end
      n_tests++; if (const_out !== 8'd1)  begin n_fail++; $display("FAIL b2b_const3 got=%0d exp=1", const_out); end
      step();
   endtask

   initial begin
      #1;
      test_reset();
      test_directed();
      test_invalid();
      test_random();
      test_interference();
      test_ena_gating();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
